// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencer and its hazard compare.
package pipe_ctrl_pkg;

  // Sequencer states; the numeric values are visible on state_o.
  typedef enum logic [1:0] {
    PCTRL_RUN   = 2'd0,
    PCTRL_FLUSH = 2'd1,
    PCTRL_DRAIN = 2'd2,
    PCTRL_HALT  = 2'd3
  } pctrl_state_e;

  // Architectural register index width and number of decode source operands.
  localparam int REG_IDX_W = 5;
  localparam int NUM_SRC   = 2;

  // One source operand collides with a producer when it is actually read
  // and names the same register.
  function automatic logic src_hazard(input logic                 use_src,
                                      input logic [REG_IDX_W-1:0] src,
                                      input logic [REG_IDX_W-1:0] dst);
    return use_src && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Purely combinational load-use detector. Kept separate so the forwarding
// unit can reuse the same compare without pulling in the sequencer.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 i_d_valid,
  input  logic                 i_e_valid,
  input  logic                 i_e_load,
  input  logic                 i_e_need_dst,
  input  logic [REG_IDX_W-1:0] i_e_dst,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic                 i_use_rs1,
  input  logic                 i_use_rs2,
  output logic                 o_load_use
);

  logic [NUM_SRC-1:0]                w_use;
  logic [NUM_SRC-1:0][REG_IDX_W-1:0] w_src;
  logic [NUM_SRC-1:0]                w_match;
  logic                              w_producer;

  assign w_use = {i_use_rs2, i_use_rs1};
  assign w_src = {i_rs2, i_rs1};

  // Register x0 is hard-wired to zero, so a load targeting it never creates
  // a dependency.
  assign w_producer = i_d_valid & i_e_valid & i_e_load & i_e_need_dst &
                      (i_e_dst != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_match[gi] = src_hazard(w_use[gi], w_src[gi], i_e_dst);
    end
  endgenerate

  assign o_load_use = w_producer & (|w_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage core: drives flush, bubble and hold
// controls of the stage registers, owns the redirect-flush and halt/drain
// sequencing, and keeps saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic [4:0]           D_rs1_i,
  input  logic [4:0]           D_rs2_i,
  input  logic                 D_use_rs1_i,
  input  logic                 D_use_rs2_i,
  input  logic                 decode_vaild_i,
  input  logic                 execute_vaild_i,
  input  logic                 memory_vaild_i,
  input  logic                 E_load_i,
  input  logic                 E_need_dstE_i,
  input  logic [4:0]           E_dstE_i,
  input  logic                 E_mispredict_i,
  input  logic                 X_busy_i,
  input  logic                 M_busy_i,
  input  logic                 halt_req_i,
  output logic                 fetch_control_o,
  output logic                 decode_control_o,
  output logic                 decode_ready_o,
  output logic                 execute_allow_in_o,
  output logic                 memory_allow_in_o,
  output logic                 pc_hold_o,
  output logic                 halted_o,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  // The flush down-counter only has to hold FLUSH_CYCLES-1.
  localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pctrl_state_e     r_state;
  logic [FC_W-1:0]  r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_exec_allow;
  logic w_mem_allow;
  logic w_in_run;
  logic w_mis_accept;
  logic w_pipe_empty;
  logic w_pc_hold;
  logic w_decode_ready;
  logic w_fetch_ctrl;
  logic w_decode_ctrl;

  pipe_ctrl_hazard_detect u_hazard (
    .i_d_valid    (decode_vaild_i),
    .i_e_valid    (execute_vaild_i),
    .i_e_load     (E_load_i),
    .i_e_need_dst (E_need_dstE_i),
    .i_e_dst      (E_dstE_i),
    .i_rs1        (D_rs1_i),
    .i_rs2        (D_rs2_i),
    .i_use_rs1    (D_use_rs1_i),
    .i_use_rs2    (D_use_rs2_i),
    .o_load_use   (w_load_use)
  );

  // A stalled memory stage backs up execute as well.
  assign w_mem_allow  = ~M_busy_i;
  assign w_exec_allow = ~M_busy_i & ~X_busy_i;

  // A mispredict seen while execute is held is not acted on; it stays on the
  // input and is re-evaluated once execute can advance.
  assign w_in_run     = (r_state == PCTRL_RUN);
  assign w_mis_accept = w_in_run & E_mispredict_i & w_exec_allow;

  // Drain completes once nothing is left in flight past fetch.
  assign w_pipe_empty = ~decode_vaild_i & ~execute_vaild_i & ~memory_vaild_i & ~M_busy_i;

  // Hold and bubble controls depend on the state and the live hazards.
  always_comb begin
    w_pc_hold      = 1'b1;
    w_decode_ready = 1'b1;
    unique case (r_state)
      PCTRL_RUN: begin
        w_pc_hold      = w_load_use | ~w_exec_allow;
        w_decode_ready = ~w_load_use;
      end
      PCTRL_FLUSH: begin
        // Fetch must run so the redirect PC is picked up.
        w_pc_hold = 1'b0;
      end
      PCTRL_DRAIN,
      PCTRL_HALT: begin
        w_pc_hold = 1'b1;
      end
      default: begin
        w_pc_hold = 1'b1;
      end
    endcase
  end

  // Squash controls for fetch_reg and decode_reg; reset forces both low.
  always_comb begin
    w_fetch_ctrl  = 1'b1;
    w_decode_ctrl = 1'b1;
    unique case (r_state)
      PCTRL_RUN: begin
        if (w_mis_accept) begin
          w_fetch_ctrl  = 1'b0;
          w_decode_ctrl = 1'b0;
        end
      end
      PCTRL_FLUSH: begin
        w_fetch_ctrl  = 1'b0;
        w_decode_ctrl = 1'b0;
      end
      PCTRL_DRAIN,
      PCTRL_HALT: begin
        // Fetch is only held (its instruction is replayed on resume);
        // decode is bubbled so nothing new enters execute.
        w_decode_ctrl = 1'b0;
      end
      default: begin
        w_decode_ctrl = 1'b0;
      end
    endcase
    if (rst) begin
      w_fetch_ctrl  = 1'b0;
      w_decode_ctrl = 1'b0;
    end
  end

  // Sequencer FSM: redirect flush window and halt/drain handshake.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state <= PCTRL_RUN;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        PCTRL_RUN: begin
          // Mispredict wins over a halt request; halt is looked at again
          // after the flush window.
          if (w_mis_accept) begin
            r_state <= PCTRL_FLUSH;
            r_cnt   <= FC_LOAD;
          end else if (halt_req_i) begin
            r_state <= PCTRL_DRAIN;
          end
        end
        PCTRL_FLUSH: begin
          if (r_cnt == '0) begin
            r_state <= PCTRL_RUN;
          end else begin
            r_cnt <= r_cnt - FC_ONE;
          end
        end
        PCTRL_DRAIN: begin
          if (!halt_req_i) begin
            r_state <= PCTRL_RUN;
          end else if (w_pipe_empty) begin
            r_state <= PCTRL_HALT;
          end
        end
        PCTRL_HALT: begin
          if (!halt_req_i) begin
            r_state <= PCTRL_RUN;
          end
        end
        default: begin
          r_state <= PCTRL_RUN;
        end
      endcase
    end
  end

  // Saturating performance counters: RUN stall cycles and accepted flushes.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_in_run && w_pc_hold && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_mis_accept && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign fetch_control_o    = w_fetch_ctrl;
  assign decode_control_o   = w_decode_ctrl;
  assign decode_ready_o     = w_decode_ready;
  assign execute_allow_in_o = w_exec_allow;
  assign memory_allow_in_o  = w_mem_allow;
  assign pc_hold_o          = w_pc_hold;
  assign halted_o           = (r_state == PCTRL_HALT);
  assign state_o            = r_state;
  assign stall_cnt_o        = r_stall_cnt;
  assign flush_cnt_o        = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model predicts every
// output for each driven cycle; a monitor on the falling edge compares.
module tb_pipe_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CMAX         = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst;
  logic [4:0]       D_rs1_i, D_rs2_i, E_dstE_i;
  logic             D_use_rs1_i, D_use_rs2_i;
  logic             decode_vaild_i, execute_vaild_i, memory_vaild_i;
  logic             E_load_i, E_need_dstE_i, E_mispredict_i;
  logic             X_busy_i, M_busy_i, halt_req_i;
  logic             fetch_control_o, decode_control_o, decode_ready_o;
  logic             execute_allow_in_o, memory_allow_in_o, pc_hold_o, halted_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk_i              (clk_i),
    .rst                (rst),
    .D_rs1_i            (D_rs1_i),
    .D_rs2_i            (D_rs2_i),
    .D_use_rs1_i        (D_use_rs1_i),
    .D_use_rs2_i        (D_use_rs2_i),
    .decode_vaild_i     (decode_vaild_i),
    .execute_vaild_i    (execute_vaild_i),
    .memory_vaild_i     (memory_vaild_i),
    .E_load_i           (E_load_i),
    .E_need_dstE_i      (E_need_dstE_i),
    .E_dstE_i           (E_dstE_i),
    .E_mispredict_i     (E_mispredict_i),
    .X_busy_i           (X_busy_i),
    .M_busy_i           (M_busy_i),
    .halt_req_i         (halt_req_i),
    .fetch_control_o    (fetch_control_o),
    .decode_control_o   (decode_control_o),
    .decode_ready_o     (decode_ready_o),
    .execute_allow_in_o (execute_allow_in_o),
    .memory_allow_in_o  (memory_allow_in_o),
    .pc_hold_o          (pc_hold_o),
    .halted_o           (halted_o),
    .state_o            (state_o),
    .stall_cnt_o        (stall_cnt_o),
    .flush_cnt_o        (flush_cnt_o)
  );

  typedef struct {
    int   cyc;
    logic fc, dc, dr, ea, ma, ph, ht;
    logic [1:0] st;
    int   sc, fl;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: mode 0 run, 1 flushing, 2 draining, 3 halted.
  int m_mode  = 0;
  int m_left  = 0;   // flush cycles still to be spent in mode 1
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req, input int c);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL cyc=%0d %s got=%0h want=%0h", c, nm, act, req);
    end
  endtask

  // Predict this cycle's outputs, queue them, then advance the model.
  task automatic step();
    exp_t e;
    bit ea, lu, run, acc;
    ea  = !X_busy_i && !M_busy_i;
    lu  = decode_vaild_i && execute_vaild_i && E_load_i && E_need_dstE_i && (E_dstE_i != 0) &&
          ((D_use_rs1_i && D_rs1_i == E_dstE_i) || (D_use_rs2_i && D_rs2_i == E_dstE_i));
    run = (m_mode == 0);
    acc = run && E_mispredict_i && ea;
    e.cyc = cyc;
    e.fc  = !(rst || acc || m_mode == 1);
    e.dc  = !(rst || acc || !run);
    e.dr  = run ? !lu : 1'b1;
    e.ea  = ea;
    e.ma  = !M_busy_i;
    e.ph  = run ? (lu || !ea) : (m_mode != 1);
    e.ht  = (m_mode == 3);
    e.st  = 2'(m_mode);
    e.sc  = m_stall;
    e.fl  = m_flush;
    sb_q.push_back(e);
    if (rst) begin
      m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (run && e.ph && m_stall < CMAX) m_stall++;
      if (acc && m_flush < CMAX) m_flush++;
      case (m_mode)
        0: if (acc) begin m_mode = 1; m_left = FLUSH_CYCLES; end
           else if (halt_req_i) m_mode = 2;
        1: begin m_left--; if (m_left == 0) m_mode = 0; end
        2: if (!halt_req_i) m_mode = 0;
           else if (!decode_vaild_i && !execute_vaild_i && !memory_vaild_i && !M_busy_i) m_mode = 3;
        default: if (!halt_req_i) m_mode = 0;
      endcase
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every driven cycle is a transaction; compare on the falling edge.
  always @(negedge clk_i) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      $display("[TB] cyc=%0d st=%0d fc=%b dc=%b dr=%b ph=%b ht=%b sc=%0d fl=%0d",
               e.cyc, state_o, fetch_control_o, decode_control_o, decode_ready_o,
               pc_hold_o, halted_o, stall_cnt_o, flush_cnt_o);
      chk("fetch_control", 32'(fetch_control_o), 32'(e.fc), e.cyc);
      chk("decode_control", 32'(decode_control_o), 32'(e.dc), e.cyc);
      chk("decode_ready", 32'(decode_ready_o), 32'(e.dr), e.cyc);
      chk("execute_allow", 32'(execute_allow_in_o), 32'(e.ea), e.cyc);
      chk("memory_allow", 32'(memory_allow_in_o), 32'(e.ma), e.cyc);
      chk("pc_hold", 32'(pc_hold_o), 32'(e.ph), e.cyc);
      chk("halted", 32'(halted_o), 32'(e.ht), e.cyc);
      chk("state", 32'(state_o), 32'(e.st), e.cyc);
      chk("stall_cnt", 32'(stall_cnt_o), 32'(e.sc), e.cyc);
      chk("flush_cnt", 32'(flush_cnt_o), 32'(e.fl), e.cyc);
    end
  end

  task automatic idle_inputs();
    rst = 0; D_rs1_i = 0; D_rs2_i = 0; D_use_rs1_i = 0; D_use_rs2_i = 0;
    decode_vaild_i = 1; execute_vaild_i = 1; memory_vaild_i = 1;
    E_load_i = 0; E_need_dstE_i = 0; E_dstE_i = 0; E_mispredict_i = 0;
    X_busy_i = 0; M_busy_i = 0; halt_req_i = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk_i);
    #1;
    // Reset cycle: controls forced low, everything cleared.
    step();
    rst = 0;
    step();

    // Load-use on rs1, then same load targeting x0.
    E_load_i = 1; E_need_dstE_i = 1; E_dstE_i = 5; D_rs1_i = 5; D_use_rs1_i = 1;
    step();
    E_dstE_i = 0; D_rs1_i = 0;
    step();
    D_rs2_i = 7; D_use_rs2_i = 1; D_use_rs1_i = 0; E_dstE_i = 7;
    step();
    idle_inputs();

    // Mispredict pulse: accept plus two flush cycles.
    E_mispredict_i = 1; step();
    E_mispredict_i = 0; repeat (3) step();

    // Mispredict held off by a busy execute unit.
    E_mispredict_i = 1; X_busy_i = 1; repeat (3) step();
    X_busy_i = 0; step();
    E_mispredict_i = 0; repeat (3) step();

    // Mispredict and halt together: flush first, then drain.
    E_mispredict_i = 1; halt_req_i = 1; step();
    E_mispredict_i = 0; repeat (3) step();
    // Drain blocked by a busy memory stage, then pipeline empties.
    memory_vaild_i = 1; M_busy_i = 1; repeat (4) step();
    decode_vaild_i = 0; execute_vaild_i = 0; memory_vaild_i = 0; M_busy_i = 0;
    repeat (2) step();
    halt_req_i = 0; repeat (2) step();
    idle_inputs();

    // Reset arriving in the middle of a flush.
    E_mispredict_i = 1; step();
    E_mispredict_i = 0; rst = 1; step();
    rst = 0; repeat (2) step();

    // Randomized phase; small register indices make hazards frequent, and the
    // narrow counters reach saturation.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      D_rs1_i         = 5'($urandom_range(0, 3));
      D_rs2_i         = 5'($urandom_range(0, 3));
      E_dstE_i        = 5'($urandom_range(0, 3));
      D_use_rs1_i     = 1'($urandom_range(0, 1));
      D_use_rs2_i     = 1'($urandom_range(0, 1));
      decode_vaild_i  = 1'($urandom_range(0, 1));
      execute_vaild_i = 1'($urandom_range(0, 1));
      memory_vaild_i  = 1'($urandom_range(0, 1));
      E_load_i        = 1'($urandom_range(0, 1));
      E_need_dstE_i   = ($urandom_range(0, 3) != 0);
      E_mispredict_i  = ($urandom_range(0, 9) == 0);
      X_busy_i        = ($urandom_range(0, 4) == 0);
      M_busy_i        = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 19) == 0) halt_req_i = ~halt_req_i;
      step();
    end

    repeat (2) @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0, cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
